cpu_decode: RTL and testbench
=============================

CPU_DECODE -- requirements
Module: cpu_decode

Interface
REQ-001 Parameter: PC_W, default 32, width of the program counter path.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: f_instr  input  32  instruction word from cpu_ifetch.
REQ-005 Port: f_pc  input  PC_W  address of f_instr.
REQ-006 Port: d_inp_vld  input  1  upstream presents valid f_instr/f_pc.
REQ-007 Port: d_inp_rdy  output  1  stage can accept this cycle; registered.
REQ-008 Port: d_flush  input  1  discard all held entries (branch redirect).
REQ-009 Port: d_otp_vld  output  1  decoded entry presented to exec.
REQ-010 Port: d_otp_rdy  input  1  exec consumes the presented entry this cycle.
REQ-011 Port: d_instr, d_pc  output  32 / PC_W  raw instruction and PC of presented entry.
REQ-012 Port: d_opcode, d_funct3, d_funct7  output  7 / 3 / 7  instr[6:0], [14:12], [31:25].
REQ-013 Port: d_rd, d_rs1, d_rs2  output  5 each  instr[11:7], [19:15], [24:20].
REQ-014 Port: d_imm  output  32  sign-extended immediate per format.
REQ-015 Port: d_illegal  output  1  unsupported encoding flag.

Function
REQ-016 Transfer in on d_inp_vld & d_inp_rdy; transfer out on d_otp_vld & d_otp_rdy.
REQ-017 Two-entry skid buffer: main register (drives outputs) plus skid register.
REQ-018 Decode is combinational on f_instr; decoded fields are stored with the entry, never recomputed at output.
REQ-019 Latency: an entry accepted in cycle N is presented in cycle N+1 when the main register is empty or draining.
REQ-020 Throughput: one entry per cycle sustained while d_otp_rdy=1.
REQ-021 States: EMPTY (0 held), ONE (main valid), FULL (main+skid valid).
REQ-022 EMPTY->ONE on accept; ONE->ONE on accept+consume; ONE->FULL on accept without consume; ONE->EMPTY on consume without accept.
REQ-023 FULL->ONE on consume (skid moves to main); no accept in FULL.
REQ-024 d_inp_rdy is 1 in EMPTY and ONE, 0 in FULL; it is a flop output, not combinational from d_otp_rdy.
REQ-025 Presented outputs are held stable while d_otp_vld=1 and d_otp_rdy=0.
REQ-026 Order preserved: entries leave in acceptance order; none dropped or duplicated.
REQ-027 Immediate formats: U (0110111, 0010111) = {instr[31:12],12'b0}; J (1101111); I (1100111, 0000011, 0010011, 1110011, 0001111); S (0100011); B (1100011); R (0110011) = 0.
REQ-028 B and J immediates have bit 0 = 0; all non-U immediates sign-extend from instr[31].
REQ-029 d_flush=1: next state EMPTY, d_otp_vld=0, any same-cycle input accept discarded; flush wins over accept and consume.
REQ-030 When d_otp_vld=0, data outputs are don't-care but must not be X after reset.

Reset
REQ-031 rst=1 at a clock edge: state EMPTY, d_otp_vld=0, d_inp_rdy=1 from the next cycle.
REQ-032 Reset values: all data outputs 0, d_illegal=0.
REQ-033 Reset mid-operation discards both held entries; rst has priority over d_flush and all handshakes.

Configuration
REQ-034 Macro DECODE_ILLEGAL_CHK_EN defined: d_illegal=1 when instr[1:0]!=2'b11 or opcode not listed in REQ-027; entry still passed through.
REQ-035 Macro DECODE_ILLEGAL_CHK_EN undefined: d_illegal tied to 0, and no checking logic is built.

Verification
REQ-036 Input 0x12345537, d_otp_rdy=1 -> next cycle d_otp_vld=1, d_rd=10, d_imm=0x12345000, d_opcode=0x37.
REQ-037 Input 0xFFF00093 (addi x1,x0,-1) -> d_rd=1, d_rs1=0, d_imm=0xFFFFFFFF; then 0x0020A423 (sw x2,8(x1)) -> d_rs1=1, d_rs2=2, d_imm=0x00000008.
REQ-038 Input 0xFE000EE3 (beq x0,x0,-4) at f_pc=0x100 -> d_imm=0xFFFFFFFC, d_pc=0x100.
REQ-039 Three back-to-back inputs with d_otp_rdy=0 -> two accepted, d_inp_rdy=0 from the cycle after the second accept; release d_otp_rdy -> three entries exit in order on consecutive cycles.
REQ-040 FULL state plus d_flush=1 with d_inp_vld=1 -> next cycle d_otp_vld=0, d_inp_rdy=1, nothing emitted.
REQ-041 Input 0x00000000 -> d_illegal=1 with DECODE_ILLEGAL_CHK_EN defined, d_illegal=0 without.

Source files
------------

// File: rtl/cpu_decode.sv
// cpu_decode: instruction decode stage built around a two-entry skid buffer.
//
// The instruction word on f_instr is decoded combinationally (register fields
// and a sign-extended immediate) and captured together with its raw word and
// PC. The main register drives the outputs. The skid register catches one
// extra entry when exec stalls. Because of the skid register, d_inp_rdy can
// be a flop output.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   f_instr, f_pc        instruction word and its address from fetch
//   d_inp_vld/d_inp_rdy  upstream handshake (d_inp_rdy is registered)
//   d_flush              drop every held entry (branch redirect)
//   d_otp_vld/d_otp_rdy  downstream handshake towards exec
//   d_instr, d_pc        raw instruction and PC of the presented entry
//   d_opcode, d_funct3, d_funct7, d_rd, d_rs1, d_rs2, d_imm  decoded fields
//   d_illegal            unsupported encoding flag
//
// Build option: define DECODE_ILLEGAL_CHK_EN to build the illegal-encoding
// check. Without it, d_illegal is tied low.
module cpu_decode #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     f_instr,
  input  logic [PC_W-1:0] f_pc,
  input  logic            d_inp_vld,
  output logic            d_inp_rdy,
  input  logic            d_flush,
  output logic            d_otp_vld,
  input  logic            d_otp_rdy,
  output logic [31:0]     d_instr,
  output logic [PC_W-1:0] d_pc,
  output logic [6:0]      d_opcode,
  output logic [2:0]      d_funct3,
  output logic [6:0]      d_funct7,
  output logic [4:0]      d_rd,
  output logic [4:0]      d_rs1,
  output logic [4:0]      d_rs2,
  output logic [31:0]     d_imm,
  output logic            d_illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic            illegal;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   rdy_q, rdy_d;
  entry_t dec;
  logic   accept;
  logic   consume;

  // Combinational decode of the incoming word.
  always_comb begin
    dec        = '0;
    dec.instr  = f_instr;
    dec.pc     = f_pc;
    dec.opcode = f_instr[6:0];
    dec.funct3 = f_instr[14:12];
    dec.funct7 = f_instr[31:25];
    dec.rd     = f_instr[11:7];
    dec.rs1    = f_instr[19:15];
    dec.rs2    = f_instr[24:20];
    case (f_instr[6:0])
      7'b0110111, 7'b0010111:
        dec.imm = {f_instr[31:12], 12'b0};
      7'b1101111:
        dec.imm = {{11{f_instr[31]}}, f_instr[31], f_instr[19:12],
                   f_instr[20], f_instr[30:21], 1'b0};
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0001111:
        dec.imm = {{20{f_instr[31]}}, f_instr[31:20]};
      7'b0100011:
        dec.imm = {{20{f_instr[31]}}, f_instr[31:25], f_instr[11:7]};
      7'b1100011:
        dec.imm = {{19{f_instr[31]}}, f_instr[31], f_instr[7],
                   f_instr[30:25], f_instr[11:8], 1'b0};
      default:
        dec.imm = '0;
    endcase
`ifdef DECODE_ILLEGAL_CHK_EN
    dec.illegal = (f_instr[1:0] != 2'b11) ||
                  !(f_instr[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111,
                                         7'b1100111, 7'b0000011, 7'b0010011,
                                         7'b1110011, 7'b0001111, 7'b0100011,
                                         7'b1100011, 7'b0110011});
`else
    dec.illegal = 1'b0;
`endif
  end

  // Next-state and buffer steering. rdy_q is low exactly in FULL, so gating
  // accept with it blocks loads while both registers are occupied.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    accept  = d_inp_vld && rdy_q;
    consume = (state_q != ST_EMPTY) && d_otp_rdy;
    if (d_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = dec;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = ST_FULL;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    rdy_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign d_inp_rdy = rdy_q;
  assign d_otp_vld = (state_q != ST_EMPTY);
  assign d_instr   = main_q.instr;
  assign d_pc      = main_q.pc;
  assign d_opcode  = main_q.opcode;
  assign d_funct3  = main_q.funct3;
  assign d_funct7  = main_q.funct7;
  assign d_rd      = main_q.rd;
  assign d_rs1     = main_q.rs1;
  assign d_rs2     = main_q.rs2;
  assign d_imm     = main_q.imm;
  assign d_illegal = main_q.illegal;

endmodule

// File: tb/tb_cpu_decode.sv
// Testbench for cpu_decode: directed cases plus randomized traffic, with a
// queue scoreboard fed from the input handshake and drained by an output
// monitor.
module tb_cpu_decode;

  localparam int unsigned PC_W = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     f_instr = '0;
  logic [PC_W-1:0] f_pc = '0;
  logic            d_inp_vld = 1'b0;
  logic            d_inp_rdy;
  logic            d_flush = 1'b0;
  logic            d_otp_vld;
  logic            d_otp_rdy = 1'b0;
  logic [31:0]     d_instr;
  logic [PC_W-1:0] d_pc;
  logic [6:0]      d_opcode;
  logic [2:0]      d_funct3;
  logic [6:0]      d_funct7;
  logic [4:0]      d_rd, d_rs1, d_rs2;
  logic [31:0]     d_imm;
  logic            d_illegal;

  cpu_decode #(.PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .f_instr(f_instr), .f_pc(f_pc),
    .d_inp_vld(d_inp_vld), .d_inp_rdy(d_inp_rdy), .d_flush(d_flush),
    .d_otp_vld(d_otp_vld), .d_otp_rdy(d_otp_rdy), .d_instr(d_instr),
    .d_pc(d_pc), .d_opcode(d_opcode), .d_funct3(d_funct3),
    .d_funct7(d_funct7), .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_imm(d_imm), .d_illegal(d_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [31:0]     imm;
    logic            ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   out_cnt = 0;
  logic mon_en = 1'b0;
  int   rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random

`ifdef DECODE_ILLEGAL_CHK_EN
  localparam logic ILL_CHK = 1'b1;
`else
  localparam logic ILL_CHK = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference decode written from the immediate-format rules with arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    exp_t        e;
    logic [31:0] sgn;
    e.instr = ins;
    e.pc    = pc;
    sgn     = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    case (ins[6:0])
      7'h37, 7'h17: e.imm = ins & 32'hFFFF_F000;
      7'h6F: e.imm = (sgn & 32'hFFF0_0000) + 32'(ins[19:12]) * 4096
                     + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
      7'h67, 7'h03, 7'h13, 7'h73, 7'h0F: e.imm = 32'($signed(ins) >>> 20);
      7'h23: e.imm = 32'($signed(ins) >>> 25) * 32 + 32'(ins[11:7]);
      7'h63: e.imm = (sgn & 32'hFFFF_F000) + 32'(ins[7]) * 2048
                     + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
      default: e.imm = 32'h0;
    endcase
    e.ill = ILL_CHK && ((ins[1:0] != 2'b11) ||
            !(ins[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                               7'h73, 7'h0F, 7'h23, 7'h63, 7'h33}));
    return e;
  endfunction

  // Input side: record accepted entries; flush/reset empty the scoreboard.
  always @(negedge clk) begin : push_side
    logic acc, clr;
    exp_t e;
    acc = d_inp_vld && d_inp_rdy;
    clr = d_flush || rst;
    e   = model(f_instr, f_pc);
    #1;
    if (clr) sb.delete();
    else if (acc) sb.push_back(e);
  end

  // Output side: compare the presented entry and handshake flags with the
  // scoreboard contents, pop on a transfer.
  always @(negedge clk) begin : monitor
    if (mon_en) begin
      chk("otp_vld", 64'(d_otp_vld), 64'(sb.size() != 0));
      chk("inp_rdy", 64'(d_inp_rdy), 64'(sb.size() < 2));
      if (d_otp_vld && sb.size() > 0) begin
        chk("instr",   64'(d_instr),   64'(sb[0].instr));
        chk("pc",      64'(d_pc),      64'(sb[0].pc));
        chk("opcode",  64'(d_opcode),  64'(sb[0].instr[6:0]));
        chk("funct3",  64'(d_funct3),  64'(sb[0].instr[14:12]));
        chk("funct7",  64'(d_funct7),  64'(sb[0].instr[31:25]));
        chk("rd",      64'(d_rd),      64'(sb[0].instr[11:7]));
        chk("rs1",     64'(d_rs1),     64'(sb[0].instr[19:15]));
        chk("rs2",     64'(d_rs2),     64'(sb[0].instr[24:20]));
        chk("imm",     64'(d_imm),     64'(sb[0].imm));
        chk("illegal", 64'(d_illegal), 64'(sb[0].ill));
        if (d_otp_rdy && !d_flush && !rst) begin
          void'(sb.pop_front());
          out_cnt++;
        end
      end
    end
  end

  always @(posedge clk) begin : rdy_driver
    #2;
    case (rdy_mode)
      0: d_otp_rdy = 1'b0;
      1: d_otp_rdy = 1'b1;
      default: d_otp_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    int unsigned n = 0;
    f_instr   = ins;
    f_pc      = pc;
    d_inp_vld = 1'b1;
    forever begin
      @(negedge clk);
      if (d_inp_rdy || n > 200) break;
      n++;
    end
    chk("send_accept", 64'(d_inp_rdy), 64'd1);
    @(posedge clk);
    #1;
    d_inp_vld = 1'b0;
  endtask

  initial begin
    logic [6:0]  ops [11];
    logic [31:0] ins;
    int          cnt0;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h33};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_vld",     64'(d_otp_vld), 64'd0);
    chk("rst_rdy",     64'(d_inp_rdy), 64'd1);
    chk("rst_instr",   64'(d_instr),   64'd0);
    chk("rst_imm",     64'(d_imm),     64'd0);
    chk("rst_illegal", 64'(d_illegal), 64'd0);
    mon_en = 1'b1;
    step();

    // LUI
    rdy_mode = 1;
    send(32'h1234_5537, 32'h40);
    @(negedge clk);
    chk("lui_vld",    64'(d_otp_vld), 64'd1);
    chk("lui_rd",     64'(d_rd),      64'd10);
    chk("lui_imm",    64'(d_imm),     64'h1234_5000);
    chk("lui_opcode", 64'(d_opcode),  64'h37);
    step();

    // addi then sw
    send(32'hFFF0_0093, 32'h44);
    @(negedge clk);
    chk("addi_rd",  64'(d_rd),  64'd1);
    chk("addi_rs1", 64'(d_rs1), 64'd0);
    chk("addi_imm", 64'(d_imm), 64'hFFFF_FFFF);
    step();
    send(32'h0020_A423, 32'h48);
    @(negedge clk);
    chk("sw_rs1", 64'(d_rs1), 64'd1);
    chk("sw_rs2", 64'(d_rs2), 64'd2);
    chk("sw_imm", 64'(d_imm), 64'h8);
    step();

    // beq with negative offset
    send(32'hFE00_0EE3, 32'h100);
    @(negedge clk);
    chk("beq_imm", 64'(d_imm), 64'hFFFF_FFFC);
    chk("beq_pc",  64'(d_pc),  64'h100);
    step();

    // all-zero word
    send(32'h0, 32'h104);
    @(negedge clk);
    chk("zero_illegal", 64'(d_illegal), 64'(ILL_CHK));
    step();

    // Stall: two accepted, third waits; release and drain in order
    repeat (3) step();
    rdy_mode = 0;
    step();
    send(32'h0010_0113, 32'h200);
    send(32'h0020_0193, 32'h204);
    @(negedge clk);
    chk("full_rdy_low", 64'(d_inp_rdy), 64'd0);
    step();
    fork
      send(32'h0030_0213, 32'h208);
      begin
        repeat (3) step();
        cnt0 = out_cnt;
        rdy_mode = 1;
      end
    join
    @(negedge clk);
    #1;
    chk("drain_consecutive", 64'(out_cnt - cnt0), 64'd3);
    step();

    // Flush while FULL with a concurrent input offer
    repeat (3) step();
    rdy_mode = 0;
    step();
    send(32'h0050_0293, 32'h300);
    send(32'h0060_0313, 32'h304);
    d_flush   = 1'b1;
    d_inp_vld = 1'b1;
    f_instr   = 32'h0070_0393;
    step();
    d_flush   = 1'b0;
    d_inp_vld = 1'b0;
    rdy_mode  = 1;
    @(negedge clk);
    chk("flush_vld", 64'(d_otp_vld), 64'd0);
    chk("flush_rdy", 64'(d_inp_rdy), 64'd1);
    cnt0 = out_cnt;
    step();
    repeat (3) step();
    chk("flush_nothing_out", 64'(out_cnt - cnt0), 64'd0);

    // Randomized traffic with random backpressure and occasional flushes
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 29);
      if (r == 0) begin
        d_flush = 1'b1;
        step();
        d_flush = 1'b0;
      end else if (r < 5) begin
        step();
      end else begin
        ins = $urandom;
        if ($urandom_range(0, 7) != 0) begin
          ins[6:0] = ops[$urandom_range(0, 10)];
        end
        send(ins, PC_W'($urandom));
      end
    end

    // Reset while FULL
    rdy_mode = 1;
    repeat (5) step();
    rdy_mode = 0;
    step();
    send(32'h1234_5537, 32'h500);
    send(32'hFFF0_0093, 32'h504);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_vld",   64'(d_otp_vld), 64'd0);
    chk("midrst_rdy",   64'(d_inp_rdy), 64'd1);
    chk("midrst_instr", 64'(d_instr),   64'd0);
    chk("midrst_pc",    64'(d_pc),      64'd0);
    chk("midrst_imm",   64'(d_imm),     64'd0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
